// File: rtl/instr_queue_mw_if.sv
// ============================================================================
//  Module      : instr_queue_mw_if
//  Description : Bundle of signals between the fetch unit, the multi-wide
//                instruction queue and decode.
//                slave  modport : the queue itself
//                master modport : the fetch/decode side driving it
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_queue_mw_if #(
    parameter int INST_W     = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FETCH_W    = 2,
    parameter int ISSUE_W    = 2
);
    localparam int POP_W = $clog2(ISSUE_W + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                          flush_i;
    logic                          push_valid_i;
    logic                          push_ready_o;
    logic [FETCH_W*INST_W-1:0]     push_inst_i;
    logic [FETCH_W-1:0]            push_mask_i;
    logic [ADDR_WIDTH-1:0]         push_pc_i;
    logic                          push_excp_i;
    logic [POP_W-1:0]              pop_count_i;
    logic [ISSUE_W-1:0]            out_valid_o;
    logic [ISSUE_W*INST_W-1:0]     out_inst_o;
    logic [ISSUE_W*ADDR_WIDTH-1:0] out_pc_o;
    logic [ISSUE_W-1:0]            out_excp_o;
    logic [CNT_W-1:0]              count_o;

    modport slave (
        input  flush_i, push_valid_i, push_inst_i, push_mask_i, push_pc_i,
               push_excp_i, pop_count_i,
        output push_ready_o, out_valid_o, out_inst_o, out_pc_o, out_excp_o,
               count_o
    );

    modport master (
        output flush_i, push_valid_i, push_inst_i, push_mask_i, push_pc_i,
               push_excp_i, pop_count_i,
        input  push_ready_o, out_valid_o, out_inst_o, out_pc_o, out_excp_o,
               count_o
    );
endinterface

`default_nettype wire

// File: rtl/instr_queue_mw.sv
// ============================================================================
//  Module      : instr_queue_mw
//  Description : Multi-wide instruction queue between IFU and decode.
//                Accepts up to FETCH_W instructions per cycle, presents the
//                ISSUE_W oldest entries combinationally. Each entry holds
//                inst, PC and a misaligned-fetch exception flag. An accepted
//                exception group blocks further fetch until flush.
//  Ports       : clk   - clock
//                rst   - asynchronous active-high reset
//                q_if  - instr_queue_mw_if.slave (push group, pop count,
//                        head lanes, occupancy, flush)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_queue_mw #(
    parameter int INST_W     = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FETCH_W    = 2,
    parameter int ISSUE_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_queue_mw_if.slave    q_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_BLOCKED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [INST_W-1:0]     mem_inst_q [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_q   [DEPTH];
    logic                  mem_excp_q [DEPTH];

    logic                  w_push_ready;
    logic                  w_push_fire;
    logic [CNT_W-1:0]      w_mask_n;
    logic [CNT_W-1:0]      w_push_n;
    logic [CNT_W-1:0]      w_pop_req;
    logic [CNT_W-1:0]      w_pop_lim;
    logic [CNT_W-1:0]      w_pop_n;

    logic                  w_lane_we   [FETCH_W];
    logic [PTR_W-1:0]      w_wr_idx    [FETCH_W];
    logic [INST_W-1:0]     w_lane_inst [FETCH_W];
    logic [ADDR_WIDTH-1:0] w_lane_pc   [FETCH_W];
    logic [PTR_W-1:0]      w_rd_idx    [ISSUE_W];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. Flush always wins and returns to RUN.
    always_comb begin
        state_d = state_q;
        if (q_if.flush_i) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN && w_push_fire && q_if.push_excp_i) begin
            state_d = S_BLOCKED;
        end
    end

    // FSM: outputs. Ready looks only at registered occupancy, so a pop in
    // the same cycle never makes room for a push.
    always_comb begin
        w_push_ready = (state_q == S_RUN) &&
                       ((CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W));
        q_if.push_ready_o = w_push_ready;
    end

    // ------------------------------------------------------------------
    // Push side
    // ------------------------------------------------------------------
    assign w_push_fire = q_if.push_valid_i && w_push_ready && !q_if.flush_i;

    always_comb begin
        w_mask_n = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            w_mask_n = w_mask_n + CNT_W'(q_if.push_mask_i[k]);
        end
        // An exception group collapses to a single marker entry.
        if (!w_push_fire) begin
            w_push_n = '0;
        end else if (q_if.push_excp_i) begin
            w_push_n = CNT_W'(1);
        end else begin
            w_push_n = w_mask_n;
        end
    end

    // Mask is contiguous from lane 0, so lane k lands at wr_ptr + k.
    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            w_lane_we[k]   = w_push_fire &&
                             (q_if.push_excp_i ? (k == 0) : q_if.push_mask_i[k]);
            w_wr_idx[k]    = wr_ptr_q + PTR_W'(k);
            w_lane_inst[k] = q_if.push_excp_i ? '0 : q_if.push_inst_i[k*INST_W +: INST_W];
            w_lane_pc[k]   = q_if.push_pc_i + ADDR_WIDTH'(4 * k);
        end
    end

    // Storage needs no reset: every lane read is gated by count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (w_lane_we[k]) begin
                mem_inst_q[w_wr_idx[k]] <= w_lane_inst[k];
                mem_pc_q[w_wr_idx[k]]   <= w_lane_pc[k];
                mem_excp_q[w_wr_idx[k]] <= q_if.push_excp_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pop side: request clamped to the number of valid output lanes
    // ------------------------------------------------------------------
    always_comb begin
        w_pop_req = CNT_W'(q_if.pop_count_i);
        w_pop_lim = (count_q < CNT_W'(ISSUE_W)) ? count_q : CNT_W'(ISSUE_W);
        if (q_if.flush_i) begin
            w_pop_n = '0;
        end else if (w_pop_req > w_pop_lim) begin
            w_pop_n = w_pop_lim;
        end else begin
            w_pop_n = w_pop_req;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop_n);
        wr_ptr_d = wr_ptr_q + PTR_W'(w_push_n);
        count_d  = count_q + w_push_n - w_pop_n;
        if (q_if.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Head lanes, zero read latency; lanes beyond occupancy drive 0
    // ------------------------------------------------------------------
    always_comb begin
        q_if.out_valid_o = '0;
        q_if.out_inst_o  = '0;
        q_if.out_pc_o    = '0;
        q_if.out_excp_o  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_rd_idx[k] = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                q_if.out_valid_o[k]                        = 1'b1;
                q_if.out_inst_o[k*INST_W +: INST_W]        = mem_inst_q[w_rd_idx[k]];
                q_if.out_pc_o[k*ADDR_WIDTH +: ADDR_WIDTH]  = mem_pc_q[w_rd_idx[k]];
                q_if.out_excp_o[k]                         = mem_excp_q[w_rd_idx[k]];
            end
        end
    end

    assign q_if.count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_queue_mw.sv
// ============================================================================
//  Module      : tb_instr_queue_mw
//  Description : Self-checking bench for instr_queue_mw (DEPTH=8, FETCH_W=2,
//                ISSUE_W=2) with a queue-based reference of expected entries.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_queue_mw;
    localparam int INST_W     = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int DEPTH      = 8;
    localparam int FETCH_W    = 2;
    localparam int ISSUE_W    = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        excp;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_queue_mw_if #(
        .INST_W(INST_W), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH),
        .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)
    ) q_if ();

    instr_queue_mw #(
        .INST_W(INST_W), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH),
        .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .q_if (q_if)
    );

    ent_t exp_q[$];
    logic m_blocked;
    int   n_chk;
    int   n_fail;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return !m_blocked && ((DEPTH - exp_q.size()) >= FETCH_W);
    endfunction

    // Compare every DUT output against the reference head.
    task automatic check_outputs();
        int         sz;
        logic [1:0] ev;
        sz = exp_q.size();
        for (int k = 0; k < ISSUE_W; k++) ev[k] = (sz > k);
        check_eq("count", 64'(q_if.count_o), 64'(sz));
        check_eq("ready", 64'(q_if.push_ready_o), 64'(model_ready()));
        check_eq("valid", 64'(q_if.out_valid_o), 64'(ev));
        for (int k = 0; k < ISSUE_W; k++) begin
            if (k < sz) begin
                check_eq($sformatf("inst%0d", k), 64'(q_if.out_inst_o[k*INST_W +: INST_W]), 64'(exp_q[k].inst));
                check_eq($sformatf("pc%0d", k), 64'(q_if.out_pc_o[k*ADDR_WIDTH +: ADDR_WIDTH]), 64'(exp_q[k].pc));
                check_eq($sformatf("excp%0d", k), 64'(q_if.out_excp_o[k]), 64'(exp_q[k].excp));
            end else begin
                check_eq($sformatf("inst%0d_idle", k), 64'(q_if.out_inst_o[k*INST_W +: INST_W]), 64'(0));
                check_eq($sformatf("pc%0d_idle", k), 64'(q_if.out_pc_o[k*ADDR_WIDTH +: ADDR_WIDTH]), 64'(0));
                check_eq($sformatf("excp%0d_idle", k), 64'(q_if.out_excp_o[k]), 64'(0));
            end
        end
    endtask

    // One clock cycle: drive, check current outputs, update reference, clock.
    task automatic cyc(input logic pv, input logic [1:0] mask, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [31:0] pc, input logic excp,
                       input int pop, input logic fl);
        logic rdy;
        ent_t e;
        assert (mask != 2'b10) else $error("non-contiguous push mask driven");
        assert (pop <= exp_q.size() && pop <= ISSUE_W) else $error("pop_count exceeds valid lanes");
        q_if.push_valid_i = pv;
        q_if.push_mask_i  = mask;
        q_if.push_inst_i  = {i1, i0};
        q_if.push_pc_i    = pc;
        q_if.push_excp_i  = excp;
        q_if.pop_count_i  = 2'(pop);
        q_if.flush_i      = fl;
        check_outputs();
        rdy = model_ready();
        if (fl) begin
            exp_q.delete();
            m_blocked = 1'b0;
        end else begin
            for (int k = 0; k < pop; k++) void'(exp_q.pop_front());
            if (pv && rdy) begin
                if (excp) begin
                    e.inst = '0; e.pc = pc; e.excp = 1'b1;
                    exp_q.push_back(e);
                    m_blocked = 1'b1;
                end else begin
                    if (mask[0]) begin e.inst = i0; e.pc = pc;     e.excp = 1'b0; exp_q.push_back(e); end
                    if (mask[1]) begin e.inst = i1; e.pc = pc + 4; e.excp = 1'b0; exp_q.push_back(e); end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int pop);
        cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, pop, 1'b0);
    endtask

    initial begin
        int         sz;
        int         pmax;
        logic [1:0] msk;
        n_chk     = 0;
        n_fail    = 0;
        m_blocked = 1'b0;
        rst       = 1'b1;
        q_if.push_valid_i = 1'b0;
        q_if.push_mask_i  = '0;
        q_if.push_inst_i  = '0;
        q_if.push_pc_i    = '0;
        q_if.push_excp_i  = 1'b0;
        q_if.pop_count_i  = '0;
        q_if.flush_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Reset release, then a full two-lane push and a double pop.
        idle(0);
        cyc(1'b1, 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 32'h100, 1'b0, 0, 1'b0);
        idle(2);
        idle(0);

        // Fill to DEPTH, then drain one at a time watching ready.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 2'b11, 32'h1000 + 2*i, 32'h1001 + 2*i, 32'h300 + 8*i, 1'b0, 0, 1'b0);
        idle(1);
        idle(1);
        idle(0);
        repeat (3) idle(2);
        idle(0);

        // Single-lane streaming across pointer wrap with occupancy held at 1.
        cyc(1'b1, 2'b01, 32'h5000, 32'h0, 32'h200, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 20; i++)
            cyc(1'b1, 2'b01, 32'h5000 + i, 32'h0, 32'h200 + 4*i, 1'b0, 1, 1'b0);
        idle(1);

        // Exception group: one marker entry, fetch blocked until flush.
        cyc(1'b1, 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h202, 1'b1, 0, 1'b0);
        cyc(1'b1, 2'b11, 32'h7, 32'h8, 32'h400, 1'b0, 0, 1'b0);
        idle(0);
        cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b1);
        idle(0);

        // Flush beats a simultaneous push and pop.
        cyc(1'b1, 2'b11, 32'h11, 32'h12, 32'h500, 1'b0, 0, 1'b0);
        cyc(1'b1, 2'b11, 32'h13, 32'h14, 32'h508, 1'b0, 0, 1'b0);
        cyc(1'b1, 2'b11, 32'h15, 32'h16, 32'h510, 1'b0, 2, 1'b1);
        idle(0);
        cyc(1'b1, 2'b01, 32'h17, 32'h0, 32'h520, 1'b0, 0, 1'b0);
        idle(1);

        // Asynchronous reset in the middle of a cycle.
        cyc(1'b1, 2'b11, 32'h21, 32'h22, 32'h600, 1'b0, 0, 1'b0);
        cyc(1'b1, 2'b11, 32'h23, 32'h24, 32'h608, 1'b1, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        m_blocked = 1'b0;
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(0);

        // Random mix of pushes, pops, exceptions and flushes.
        for (int i = 0; i < 300; i++) begin
            sz   = exp_q.size();
            pmax = (sz < ISSUE_W) ? sz : ISSUE_W;
            case ($urandom_range(0, 2))
                0:       msk = 2'b00;
                1:       msk = 2'b01;
                default: msk = 2'b11;
            endcase
            cyc(1'($urandom_range(0, 1)), msk, $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
                ($urandom_range(0, 15) == 0), $urandom_range(0, pmax),
                (m_blocked && $urandom_range(0, 3) == 0) || ($urandom_range(0, 49) == 0));
        end
        idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
